// File: rtl/if_prefetch_q_pkg.sv
// if_prefetch_q_pkg
//   Shared types and constants for the instruction prefetch queue.
//   ifq_entry_t : one buffered fetch {pc, ir, pc4, misalign}
//   ifq_state_t : fetch engine state (FETCH, HALT_MIS)
//   NOP_IR      : instruction word carried by a misaligned-target marker entry
//   IFQ_RESET_PC: default first fetch address after reset
package if_prefetch_q_pkg;

    localparam int          IFQ_XLEN     = 32;
    localparam logic [31:0] NOP_IR       = 32'h0000_0013;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH    = 1'b0,
        HALT_MIS = 1'b1
    } ifq_state_t;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] ir;
        logic [IFQ_XLEN-1:0] pc4;
        logic                misalign;
    } ifq_entry_t;

    // Builds an entry; pc4 wraps modulo 2^XLEN like the fetch address does.
    function automatic ifq_entry_t make_entry(input logic [IFQ_XLEN-1:0] pc,
                                              input logic [IFQ_XLEN-1:0] ir,
                                              input logic                misalign);
        ifq_entry_t e;
        e.pc       = pc;
        e.ir       = ir;
        e.pc4      = pc + IFQ_XLEN'(4);
        e.misalign = misalign;
        return e;
    endfunction

endpackage

// File: rtl/if_prefetch_q_if.sv
// if_prefetch_q_if
//   Bundles the instruction-memory port (IAD/IDT/ACKI_n), the redirect
//   request and the decode-side consumer port of the prefetch queue.
//   master: the prefetch queue itself
//   slave : the environment (instruction memory, branch unit, decode)
interface if_prefetch_q_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic [XLEN-1:0]        IAD;
    logic [XLEN-1:0]        IDT;
    logic                   ACKI_n;
    logic                   redirect;
    logic [XLEN-1:0]        redirect_pc;
    logic                   deq;
    logic                   valid;
    logic [XLEN-1:0]        pc_out;
    logic [XLEN-1:0]        ir_out;
    logic [XLEN-1:0]        pc4_out;
    logic                   misalign_out;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output IAD, valid, pc_out, ir_out, pc4_out, misalign_out, level,
        input  IDT, ACKI_n, redirect, redirect_pc, deq
    );

    modport slave (
        input  IAD, valid, pc_out, ir_out, pc4_out, misalign_out, level,
        output IDT, ACKI_n, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/if_prefetch_q_fifo.sv
// ifq_fifo
//   Generic DEPTH x ifq_entry_t circular buffer.
//   clk/rst   : clock, synchronous active-high reset
//   flush     : empty the buffer (wins over push/pop)
//   push/push_data : write one entry at the tail
//   pop       : drop the head entry
//   count     : registered entry count
//   head      : entry at the head pointer (meaningful when count != 0)
module ifq_fifo
    import if_prefetch_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  ifq_entry_t             push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output ifq_entry_t             head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_ptr] <= push_data;
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/if_prefetch_q.sv
// if_prefetch_q
//   Instruction prefetch queue between the PC and the IF/ID boundary.
//   Fetches sequentially ahead of decode and buffers DEPTH entries of
//   {pc, ir, pc+4, misaligned}; flushes and restarts on redirect.
//   clk : clock          rst : synchronous active-high reset
//   bus : if_prefetch_q_if.master (IAD/IDT/ACKI_n, redirect, deq, head outputs, level)
//   Optional feature macro IFQ_BYPASS_EN: when the queue is empty the word
//   returned by memory is presented on the outputs in the same cycle.
module if_prefetch_q
    import if_prefetch_q_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = IFQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFQ_RESET_PC
) (
    input logic               clk,
    input logic               rst,
    if_prefetch_q_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifq_state_t       state_q;
    ifq_state_t       state_d;
    logic [XLEN-1:0]  fetch_pc;
    logic             mis_pending;
    logic [CNT_W-1:0] fifo_count;
    ifq_entry_t       fifo_head;
    ifq_entry_t       push_data;
    logic             fifo_push;
    logic             fifo_pop;
    logic             head_valid;
    logic             has_room;
    logic             fetch_take;
    logic             bypass_active;
    logic             bypass_take;
    logic             redir_aligned;

    assign redir_aligned = (bus.redirect_pc[1:0] == 2'b00);

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // State register; the marker-push flag only ever lives for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            mis_pending <= 1'b0;
        end else begin
            state_q     <= state_d;
            mis_pending <= bus.redirect && !redir_aligned;
        end
    end

    // Only a redirect moves the machine; HALT_MIS is otherwise sticky.
    always_comb begin
        state_d = state_q;
        if (bus.redirect) state_d = redir_aligned ? FETCH : HALT_MIS;
    end

    // Push/pop control and head presentation.
    always_comb begin
        head_valid    = (fifo_count != '0);
        has_room      = (fifo_count < CNT_W'(DEPTH)) || (bus.deq && head_valid);
        bypass_active = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass_active = (state_q == FETCH) && !head_valid && !bus.ACKI_n && !bus.redirect;
`endif
        bypass_take   = bypass_active && bus.deq;
        fetch_take    = (state_q == FETCH) && !bus.ACKI_n && !bus.redirect && has_room;
        fifo_pop      = bus.deq && head_valid && !bus.redirect;

        fifo_push = 1'b0;
        push_data = make_entry(fetch_pc, bus.IDT, 1'b0);
        if (mis_pending && !bus.redirect) begin
            fifo_push = 1'b1;
            push_data = make_entry(fetch_pc, NOP_IR, 1'b1);
        end else if (fetch_take && !bypass_take) begin
            fifo_push = 1'b1;
        end

        bus.valid        = 1'b0;
        bus.pc_out       = '0;
        bus.ir_out       = '0;
        bus.pc4_out      = '0;
        bus.misalign_out = 1'b0;
        if (bypass_active) begin
            bus.valid   = 1'b1;
            bus.pc_out  = fetch_pc;
            bus.ir_out  = bus.IDT;
            bus.pc4_out = fetch_pc + XLEN'(4);
        end else if (head_valid) begin
            bus.valid        = 1'b1;
            bus.pc_out       = fifo_head.pc;
            bus.ir_out       = fifo_head.ir;
            bus.pc4_out      = fifo_head.pc4;
            bus.misalign_out = fifo_head.misalign;
        end
    end

    // A misaligned target parks fetch_pc on the target so the marker entry
    // and IAD both carry it while halted.
    always_ff @(posedge clk) begin
        if (rst)                fetch_pc <= RESET_PC;
        else if (bus.redirect)  fetch_pc <= bus.redirect_pc;
        else if (fetch_take)    fetch_pc <= fetch_pc + XLEN'(4);
    end

    assign bus.IAD   = fetch_pc;
    assign bus.level = fifo_count;

endmodule

// File: tb/tb_if_prefetch_q.sv
// tb_if_prefetch_q
//   Self-checking bench for if_prefetch_q: a queue-level reference model
//   updated every rising edge, a compare process on every falling edge,
//   and directed sequences with literal expectations.
module tb_if_prefetch_q;

    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        mis;
    } model_entry_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_prefetch_q_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

    if_prefetch_q #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    // Instruction memory answers every address with a tagged copy of it.
    assign bus.IDT = tag(bus.IAD);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    model_entry_t mq[$];
    logic [31:0]  m_pc;
    logic         m_halt;
    logic         m_pend;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched words in program order.
    always @(posedge clk) begin
        int  n;
        bit  popped;
        if (rst) begin
            mq.delete();
            m_pc   = 32'h0;
            m_halt = 1'b0;
            m_pend = 1'b0;
        end else if (bus.redirect) begin
            mq.delete();
            m_pc   = bus.redirect_pc;
            m_halt = (bus.redirect_pc[1:0] != 2'b00);
            m_pend = m_halt;
        end else if (m_pend) begin
            mq.push_back('{m_pc, 32'h0000_0013, m_pc + 32'd4, 1'b1});
            m_pend = 1'b0;
        end else begin
            n      = mq.size();
            popped = bus.deq && (n > 0);
            if (popped) void'(mq.pop_front());
            if (!m_halt && !bus.ACKI_n) begin
                if (BYP && n == 0 && bus.deq) begin
                    m_pc = m_pc + 32'd4;
                end else if (n < DEPTH || popped) begin
                    mq.push_back('{m_pc, tag(m_pc), m_pc + 32'd4, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit          e_byp;
        bit          e_valid;
        model_entry_t e;
        if (!rst) begin
            e_byp   = BYP && mq.size() == 0 && !m_halt && !bus.ACKI_n && !bus.redirect;
            e_valid = e_byp || (mq.size() > 0);
            if (e_byp) e = '{m_pc, tag(m_pc), m_pc + 32'd4, 1'b0};
            else if (mq.size() > 0) e = mq[0];
            checkOutput("valid", 32'(bus.valid), 32'(e_valid));
            checkOutput("level", 32'(bus.level), 32'(mq.size()));
            checkOutput("IAD", bus.IAD, m_pc);
            if (e_valid) begin
                checkOutput("pc_out", bus.pc_out, e.pc);
                checkOutput("ir_out", bus.ir_out, e.ir);
                checkOutput("pc4_out", bus.pc4_out, e.pc4);
                checkOutput("misalign_out", 32'(bus.misalign_out), 32'(e.mis));
            end
        end
    end

    // Drives one cycle of inputs; returns just after the rising edge.
    task automatic applyStimulus(input logic ack_n, input logic deq,
                                 input logic redir, input logic [31:0] rpc);
        bus.ACKI_n      = ack_n;
        bus.deq         = deq;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.ACKI_n = 1'b1; bus.deq = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        checkOutput("rst_valid", 32'(bus.valid), 32'd0);
        checkOutput("rst_level", 32'(bus.level), 32'd0);
        checkOutput("rst_IAD", bus.IAD, 32'h0);
        checkOutput("rst_pc_out", bus.pc_out, 32'h0);

        // Fill until full; extra returned words are dropped
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fill_level", 32'(bus.level), 32'd4);
        checkOutput("fill_IAD", bus.IAD, 32'h10);
        checkOutput("fill_pc_out", bus.pc_out, 32'h0);
        checkOutput("fill_ir_out", bus.ir_out, 32'hDEAD_0000);

        // Streaming: full + deq accepts, one entry per cycle
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stream_pc_out", bus.pc_out, 32'h18);
        checkOutput("stream_level", 32'(bus.level), 32'd4);
        checkOutput("stream_IAD", bus.IAD, 32'h28);

        // Redirect to aligned target with a full queue and deq
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput("redir_level", 32'(bus.level), 32'd0);
        checkOutput("redir_valid", 32'(bus.valid), 32'd0);
        checkOutput("redir_IAD", bus.IAD, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_pc_out", bus.pc_out, 32'h100);
        checkOutput("redir_level1", 32'(bus.level), 32'd1);

        // Wait states mid-stream hold IAD
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_IAD", bus.IAD, 32'h8);
        checkOutput("stall_level", 32'(bus.level), 32'd2);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("resume_level", 32'(bus.level), 32'd4);
        checkOutput("resume_IAD", bus.IAD, 32'h10);
        // Drain, including one deq on an empty queue
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("drain_level", 32'(bus.level), 32'd0);
        checkOutput("drain_valid", 32'(bus.valid), 32'd0);
        checkOutput("drain_IAD", bus.IAD, 32'h10);

        // Misaligned redirect: one marker entry, then halt
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
        checkOutput("mis_level0", 32'(bus.level), 32'd0);
        checkOutput("mis_IAD0", bus.IAD, 32'h102);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_level", 32'(bus.level), 32'd1);
        checkOutput("mis_pc_out", bus.pc_out, 32'h102);
        checkOutput("mis_ir_out", bus.ir_out, 32'h0000_0013);
        checkOutput("mis_pc4_out", bus.pc4_out, 32'h106);
        checkOutput("mis_flag", 32'(bus.misalign_out), 32'd1);
        checkOutput("mis_IAD", bus.IAD, 32'h102);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("mis_deq_level", 32'(bus.level), 32'd0);
        checkOutput("mis_deq_valid", 32'(bus.valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("resume200_level", 32'(bus.level), 32'd2);
        checkOutput("resume200_pc_out", bus.pc_out, 32'h200);
        checkOutput("resume200_IAD", bus.IAD, 32'h208);

        // Fetch address wraps modulo 2^32
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4_out", bus.pc4_out, 32'h0);
        checkOutput("wrap_IAD", bus.IAD, 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_next_pc", bus.pc_out, 32'h0);

`ifdef IFQ_BYPASS_EN
        // Zero-latency fetch on an empty queue
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h300);
        bus.ACKI_n = 1'b0; bus.deq = 1'b1; bus.redirect = 1'b0;
        @(negedge clk);
        checkOutput("byp_valid", 32'(bus.valid), 32'd1);
        checkOutput("byp_pc_out", bus.pc_out, 32'h300);
        checkOutput("byp_level", 32'(bus.level), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("byp_IAD", bus.IAD, 32'h304);
        checkOutput("byp_level_after", 32'(bus.level), 32'd0);
`endif

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
